obi_initiator: RTL

OBI manager-side bridge that turns a simple valid/ready command stream into OBI bus transactions and returns each response on a single-cycle response strobe. It drives the request and address phase towards an OBI peripheral, such as a register-file responder in the fabric, and tracks outstanding transactions. It reports an error response when the peripheral never answers. It sits between a command source (fabric logic, UART/SPI debug bridge) and the OBI peripheral wrapper.

---
 rtl/obi_initiator.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/obi_initiator.sv
// OBI manager bridge: turns a valid/ready command stream into OBI transactions,
// returns each answer as a one-cycle response strobe and abandons silent transactions on timeout.
module obi_initiator #(
   parameter int ADDR_W  = 24,
   parameter int DATA_W  = 32,
   parameter int MAX_OUT = 2,
   parameter int TIMEOUT = 255,
   localparam int BE_W   = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [BE_W-1:0]   cmd_be,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic              rsp_we,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              obi_req,
   output logic              obi_we,
   output logic [BE_W-1:0]   obi_be,
   output logic [ADDR_W-1:0] obi_addr,
   output logic [DATA_W-1:0] obi_wdata,
   input  logic              obi_gnt,
   input  logic              obi_rvalid,
   input  logic [DATA_W-1:0] obi_rdata,
   output logic              busy,
   output logic              proto_err
);

   localparam int CW = $clog2(MAX_OUT + 1);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [BE_W-1:0]   be_q, be_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [CW-1:0]     out_q, out_d;
   logic [MAX_OUT-1:0] wef_q, wef_d;
   logic [TW-1:0]     tmr_q, tmr_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_we_q, rsp_we_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              proto_err_q, proto_err_d;

   logic              grant, accept, rsp_hit, expire, pop;
   logic [CW-1:0]     push_idx;

   // A pending request keeps counting against the limit in its grant cycle,
   // which guarantees the outstanding count never exceeds MAX_OUT.
   assign cmd_ready = (!req_q || obi_gnt) && ((int'(out_q) + int'(req_q)) < MAX_OUT);
   assign accept    = cmd_valid && cmd_ready;
   assign grant     = req_q && obi_gnt;
   assign rsp_hit   = obi_rvalid && (out_q != '0);
   assign expire    = (TIMEOUT != 0) && (out_q != '0) && !obi_rvalid
                      && (int'(tmr_q) >= TIMEOUT - 1);
   assign pop       = rsp_hit || expire;

   always_comb begin
      req_d   = req_q;
      we_d    = we_q;
      be_d    = be_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (accept) begin
         req_d   = 1'b1;
         we_d    = cmd_we;
         be_d    = cmd_be;
         addr_d  = cmd_addr;
         wdata_d = cmd_wdata;
      end else if (grant) begin
         req_d = 1'b0;
      end
   end

   // The timer restarts on a grant or an answer so expiry is measured from the later of the two.
   always_comb begin
      out_d = out_q + CW'(grant) - CW'(pop);
      tmr_d = tmr_q;
      if ((TIMEOUT == 0) || (out_d == '0)) begin
         tmr_d = '0;
      end else if (grant || pop) begin
         tmr_d = TW'(1);
      end else begin
         tmr_d = tmr_q + TW'(1);
      end
   end

   always_comb begin
      wef_d    = wef_q;
      push_idx = out_q;
      if (pop) begin
         wef_d    = wef_q >> 1;
         push_idx = out_q - CW'(1);
      end
      if (grant) begin
         for (int i = 0; i < MAX_OUT; i++) begin
            if (CW'(i) == push_idx) begin
               wef_d[i] = we_q;
            end
         end
      end
   end

   always_comb begin
      rsp_valid_d = pop;
      rsp_we_d    = pop && wef_q[0];
      rsp_err_d   = expire;
      rsp_rdata_d = (rsp_hit && !wef_q[0]) ? obi_rdata : '0;
      proto_err_d = proto_err_q || (obi_rvalid && (out_q == '0));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         be_q        <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         out_q       <= '0;
         wef_q       <= '0;
         tmr_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_we_q    <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         req_q       <= req_d;
         we_q        <= we_d;
         be_q        <= be_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         out_q       <= out_d;
         wef_q       <= wef_d;
         tmr_q       <= tmr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_we_q    <= rsp_we_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign obi_req   = req_q;
   assign obi_we    = we_q;
   assign obi_be    = be_q;
   assign obi_addr  = addr_q;
   assign obi_wdata = wdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_we    = rsp_we_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign proto_err = proto_err_q;
   assign busy      = req_q || (out_q != '0);

endmodule
